// File: rtl/timer_pkg.sv
// Shared types and display constants for the round timer and its display scanner.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Anode pattern per scan index; index 0 drives the leftmost digit (an[3])
    localparam logic [3:0][3:0] AN_SEL = {4'b1110, 4'b1101, 4'b1011, 4'b0111};
    localparam logic [3:0]      AN_OFF = 4'b1111;

    // BCD digit to segment pattern; out-of-range codes show nothing
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/round_timer_seg7_scan.sv
// Time-multiplexed scan of the 4-digit display; digit 3 is always blank.
module seg7_scan
    import timer_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 249_999
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] i_dig2,
    input  logic [3:0] i_dig1,
    input  logic [3:0] i_dig0,
    input  logic       i_blank,
    input  logic       i_dash,
    input  logic       i_dp_on,
    output logic [6:0] o_seg,
    output logic [3:0] o_an,
    output logic       o_dp
);

    localparam int unsigned CW = (REFRESH_DIV > 0) ? $clog2(REFRESH_DIV + 1) : 1;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [6:0]    w_seg;
    logic          w_dp;

    // Scan counter and digit index
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (r_cnt == CW'(REFRESH_DIV)) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Segment and dp pattern for the digit currently selected
    always_comb begin
        w_seg = SEG_BLANK;
        w_dp  = 1'b1;
        if (!i_blank) begin
            case (r_idx)
                2'd1: begin
                    w_seg = i_dash ? SEG_DASH : seg_decode(i_dig2);
                    w_dp  = ~i_dp_on;
                end
                2'd2:    w_seg = i_dash ? SEG_DASH : seg_decode(i_dig1);
                2'd3:    w_seg = i_dash ? SEG_DASH : seg_decode(i_dig0);
                default: w_seg = SEG_BLANK;
            endcase
        end
    end

    // Registered display drive, one clock behind the index
    always_ff @(posedge clock) begin
        if (reset) begin
            o_seg <= SEG_BLANK;
            o_an  <= AN_OFF;
            o_dp  <= 1'b1;
        end else begin
            o_seg <= w_seg;
            o_an  <= AN_SEL[r_idx];
            o_dp  <= w_dp;
        end
    end

endmodule

// File: rtl/round_timer.sv
// Whole-second countdown of a game round, shown as M:SS with expiry flags.
module round_timer
    import timer_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned ROUND_SECONDS = 120,
    parameter int unsigned REFRESH_DIV   = 249_999,
    parameter int unsigned WARN_SECONDS  = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       running,
    output logic       time_up,
    output logic       game_over,
    output logic [9:0] time_left
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [3:0]  RL_MIN = 4'(ROUND_SECONDS / 60);
    localparam logic [3:0]  RL_S10 = 4'((ROUND_SECONDS % 60) / 10);
    localparam logic [3:0]  RL_S1  = 4'(ROUND_SECONDS % 10);

    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_pres;
    logic [3:0]    r_min;
    logic [3:0]    r_s10;
    logic [3:0]    r_s1;
    logic          w_wrap;
    logic          w_tick;
    logic          w_expire;
    logic          w_half;
    logic          w_blank;
    logic          w_dash;
    logic          w_dp_on;

    assign w_wrap   = (r_pres == PW'(CLK_HZ - 1));
    assign w_tick   = (r_state == RUN) && w_wrap;
    assign w_expire = w_tick && (time_left == 10'd1);
    assign w_half   = (r_pres >= PW'(CLK_HZ / 2));

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state (abort beats expiry beats pause) and display mode
    always_comb begin
        w_next  = r_state;
        w_blank = 1'b0;
        w_dash  = 1'b0;
        w_dp_on = 1'b0;
        case (r_state)
            IDLE: begin
                w_dash = 1'b1;
                if (start) w_next = RUN;
            end
            RUN: begin
                w_dp_on = (time_left > 10'(WARN_SECONDS)) || !w_half;
                if (!start)        w_next = IDLE;
                else if (w_expire) w_next = DONE;
                else if (pause)    w_next = PAUSED;
            end
            PAUSED: begin
                w_dp_on = (time_left > 10'(WARN_SECONDS)) || !w_half;
                if (!start)      w_next = IDLE;
                else if (!pause) w_next = RUN;
            end
            DONE: begin
                w_blank = w_half;
                w_dp_on = 1'b1;
                if (!start) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Second prescaler: cleared in IDLE, frozen while paused, free-running in DONE
    always_ff @(posedge clock) begin
        if (reset || w_next == IDLE) begin
            r_pres <= '0;
        end else if (r_state == RUN || r_state == DONE) begin
            r_pres <= w_wrap ? '0 : r_pres + PW'(1);
        end
    end

    // BCD countdown with binary shadow
    always_ff @(posedge clock) begin
        if (reset || w_next == IDLE) begin
            r_min     <= RL_MIN;
            r_s10     <= RL_S10;
            r_s1      <= RL_S1;
            time_left <= 10'(ROUND_SECONDS);
        end else if (w_tick) begin
            time_left <= time_left - 10'd1;
            if (r_s1 != 4'd0) begin
                r_s1 <= r_s1 - 4'd1;
            end else begin
                r_s1 <= 4'd9;
                if (r_s10 != 4'd0) begin
                    r_s10 <= r_s10 - 4'd1;
                end else begin
                    r_s10 <= 4'd5;
                    r_min <= r_min - 4'd1;
                end
            end
        end
    end

    // Status flags aligned with the state register
    always_ff @(posedge clock) begin
        if (reset) begin
            running   <= 1'b0;
            game_over <= 1'b0;
            time_up   <= 1'b0;
        end else begin
            running   <= (w_next == RUN);
            game_over <= (w_next == DONE);
            time_up   <= (r_state == RUN) && start && w_expire;
        end
    end

    seg7_scan #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_scan (
        .clock  (clock),
        .reset  (reset),
        .i_dig2 (r_min),
        .i_dig1 (r_s10),
        .i_dig0 (r_s1),
        .i_blank(w_blank),
        .i_dash (w_dash),
        .i_dp_on(w_dp_on),
        .o_seg  (seg),
        .o_an   (an),
        .o_dp   (dp)
    );

endmodule

// File: tb/tb_round_timer.sv
// Scoreboard bench for round_timer: two parameterisations share one stimulus stream.
module tb_round_timer;

    localparam int A_HZ = 10, A_RS = 3,  A_RD = 1, A_WN = 1;
    localparam int B_HZ = 4,  B_RS = 61, B_RD = 1, B_WN = 1;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

    typedef struct {
        int mode;
        int run_clk;   // clocks spent counting since the round started
        int done_clk;  // clocks spent in the expired state
        int scan_n;    // clocks since reset released
        bit time_up;
    } mdl_t;

    typedef struct {
        int         tl;
        bit         run;
        bit         tup;
        bit         go;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        bit         chk_dp;
    } exp_t;

    logic clock;
    logic reset, start, pause;
    logic [6:0] a_seg, b_seg;
    logic [3:0] a_an, b_an;
    logic       a_dp, b_dp, a_run, b_run, a_tup, b_tup, a_go, b_go;
    logic [9:0] a_tl, b_tl;

    int n_tests = 0;
    int n_fail  = 0;

    mdl_t ma, mb;
    exp_t qa[$];
    exp_t qb[$];

    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    round_timer #(.CLK_HZ(A_HZ), .ROUND_SECONDS(A_RS), .REFRESH_DIV(A_RD), .WARN_SECONDS(A_WN)) dut_a (
        .clock(clock), .reset(reset), .start(start), .pause(pause),
        .seg(a_seg), .an(a_an), .dp(a_dp), .running(a_run), .time_up(a_tup),
        .game_over(a_go), .time_left(a_tl));

    round_timer #(.CLK_HZ(B_HZ), .ROUND_SECONDS(B_RS), .REFRESH_DIV(B_RD), .WARN_SECONDS(B_WN)) dut_b (
        .clock(clock), .reset(reset), .start(start), .pause(pause),
        .seg(b_seg), .an(b_an), .dp(b_dp), .running(b_run), .time_up(b_tup),
        .game_over(b_go), .time_left(b_tl));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [3:0] an_of(input int idx);
        case (idx)
            0:       return 4'b0111;
            1:       return 4'b1011;
            2:       return 4'b1101;
            default: return 4'b1110;
        endcase
    endfunction

    // Behavioural model: remaining time = round length minus whole seconds of counting time
    function automatic void mdl_step(input int chz, input int rs, input int rdiv, input int warn,
                                     input bit rst, input bit st, input bit ps,
                                     input mdl_t mi, output mdl_t mo, output exp_t e);
        mdl_t m;
        int tl, idx;
        logic [6:0] dig;
        m = mi;
        tl  = (mi.mode == M_IDLE) ? rs : rs - mi.run_clk / chz;
        idx = (mi.scan_n / (rdiv + 1)) % 4;
        e.chk_dp = 1'b1;
        e.dp     = 1'b1;
        if (rst) begin
            e.an  = 4'b1111;
            e.seg = 7'b1111111;
        end else begin
            e.an = an_of(idx);
            case (idx)
                1:       dig = seg_tab[tl / 60];
                2:       dig = seg_tab[(tl % 60) / 10];
                3:       dig = seg_tab[tl % 10];
                default: dig = 7'b1111111;
            endcase
            if (mi.mode == M_IDLE) begin
                e.seg = (idx == 0) ? 7'b1111111 : 7'b0111111;
            end else if (mi.mode == M_DONE) begin
                e.seg    = ((mi.done_clk % chz) >= chz / 2) ? 7'b1111111 : dig;
                e.chk_dp = 1'b0;
            end else begin
                e.seg = dig;
                if (idx == 1 && (tl > warn || (mi.run_clk % chz) < chz / 2)) e.dp = 1'b0;
            end
        end
        m.time_up = 1'b0;
        if (rst) begin
            m.mode = M_IDLE; m.run_clk = 0; m.done_clk = 0; m.scan_n = 0;
        end else begin
            m.scan_n++;
            case (mi.mode)
                M_IDLE: if (st) m.mode = M_RUN;
                M_RUN: begin
                    if (!st) begin
                        m.mode = M_IDLE; m.run_clk = 0;
                    end else begin
                        m.run_clk++;
                        if (m.run_clk == rs * chz) begin
                            m.mode = M_DONE; m.done_clk = 0; m.time_up = 1'b1;
                        end else if (ps) begin
                            m.mode = M_PAUSED;
                        end
                    end
                end
                M_PAUSED: begin
                    if (!st)      begin m.mode = M_IDLE; m.run_clk = 0; end
                    else if (!ps) m.mode = M_RUN;
                end
                default: begin
                    if (!st) begin m.mode = M_IDLE; m.run_clk = 0; end
                    else     m.done_clk++;
                end
            endcase
        end
        mo    = m;
        e.tl  = (m.mode == M_IDLE) ? rs : rs - m.run_clk / chz;
        e.run = (m.mode == M_RUN);
        e.go  = (m.mode == M_DONE);
        e.tup = m.time_up;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input string p, input exp_t e, input logic [9:0] tl, input logic run,
                           input logic tup, input logic go, input logic [3:0] an_v,
                           input logic [6:0] seg_v, input logic dp_v);
        check({p, ".time_left"}, 32'(tl), 32'(e.tl));
        check({p, ".running"},   32'(run), 32'(e.run));
        check({p, ".time_up"},   32'(tup), 32'(e.tup));
        check({p, ".game_over"}, 32'(go), 32'(e.go));
        check({p, ".an"},        32'(an_v), 32'(e.an));
        check({p, ".seg"},       32'(seg_v), 32'(e.seg));
        if (e.chk_dp) check({p, ".dp"}, 32'(dp_v), 32'(e.dp));
    endtask

    // Stimulus step: drive inputs for the next edge and queue what that edge must produce
    task automatic drive(input int cycles, input bit r, input bit s, input bit p);
        exp_t ea, eb;
        mdl_t na, nb;
        repeat (cycles) begin
            @(negedge clock);
            reset = r; start = s; pause = p;
            mdl_step(A_HZ, A_RS, A_RD, A_WN, r, s, p, ma, na, ea);
            mdl_step(B_HZ, B_RS, B_RD, B_WN, r, s, p, mb, nb, eb);
            ma = na; mb = nb;
            qa.push_back(ea);
            qb.push_back(eb);
        end
    endtask

    // Monitor: after every edge, compare both DUTs with the oldest queued expectation
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            cmp_dut("A", e, a_tl, a_run, a_tup, a_go, a_an, a_seg, a_dp);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            cmp_dut("B", e, b_tl, b_run, b_tup, b_go, b_an, b_seg, b_dp);
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0;
        ma = '{M_IDLE, 0, 0, 0, 1'b0};
        mb = '{M_IDLE, 0, 0, 0, 1'b0};
        drive(3, 1, 0, 0);      // reset state
        drive(10, 0, 0, 0);     // idle scan with dashes
        drive(40, 0, 1, 0);     // start and expire round A
        drive(3, 0, 0, 0);      // back to idle with reload
        drive(12, 0, 1, 0);     // first tick
        drive(25, 0, 1, 1);     // pause holds time and prescaler
        drive(15, 0, 1, 0);     // resume, partial second remains
        drive(3, 0, 0, 0);      // abort during run
        drive(13, 0, 1, 0);
        drive(5, 0, 1, 1);      // paused
        drive(1, 1, 1, 1);      // reset while paused
        drive(3, 0, 0, 0);
        drive(260, 0, 1, 0);    // long run: A expires and blinks, B borrows through 0:59 and expires
        drive(2, 0, 0, 0);
        repeat (40) begin
            drive(int'($urandom_range(1, 15)), $urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 25);
        end
        drive(2, 1, 0, 0);
        repeat (3) @(negedge clock);
        check("queue_drain", 32'(qa.size() + qb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
